// File: rtl/gradient_frame_scheduler.sv
// Raster-to-window scheduler for the Sobel datapath: two line buffers, 3x3 window issue,
// centre-coordinate tag realignment and a credit-protected result FIFO.
module gradient_frame_scheduler #(
  parameter int IMG_WIDTH      = 256,
  parameter int IMG_HEIGHT     = 256,
  parameter int PIPE_LAT       = 4,
  parameter int OUT_FIFO_DEPTH = 8,
  parameter int XW             = $clog2(IMG_WIDTH),
  parameter int YW             = $clog2(IMG_HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    pix_in,
  input  logic          pix_in_valid,
  output logic          pix_in_ready,
  output logic [71:0]   win_data,
  output logic          win_valid,
  input  logic [10:0]   grad_mag_in,
  input  logic [1:0]    grad_dir_in,
  input  logic          grad_valid_in,
  output logic [10:0]   out_mag,
  output logic [1:0]    out_dir,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          frame_done,
  output logic          sync_err,
  output logic [1:0]    dbg_state
);

  localparam int AW = $clog2(OUT_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 11 + 2 + XW + YW;
  localparam logic [XW-1:0] COL_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] ROW_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [XW-1:0] COL_TWO  = XW'(2);
  localparam logic [YW-1:0] ROW_TWO  = YW'(2);
  localparam logic [CW-1:0] DEPTH_C  = CW'(OUT_FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [XW-1:0] col;
  logic [YW-1:0] row;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] credits;
  logic          issue_pos;
  logic          accept;
  logic          issue;
  logic          push;
  logic          pop;

  // Both handshakes (pix_in and out) transfer on a rising edge where valid & ready are
  // both high; ready never depends on valid, and a presented item is held until taken.
  assign issue_pos    = (col >= COL_TWO) && (row >= ROW_TWO);
  assign credits      = DEPTH_C - fifo_count - inflight;
  assign pix_in_ready = (state == S_RUN) && ((credits != '0) || !issue_pos);
  assign accept       = pix_in_valid && pix_in_ready;
  assign issue        = accept && issue_pos;
  assign out_valid    = (fifo_count != '0);
  assign pop          = out_valid && out_ready;
  assign dbg_state    = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      col        <= '0;
      row        <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            busy  <= 1'b1;
            col   <= '0;
            row   <= '0;
          end
        end
        S_RUN: begin
          if (accept) begin
            if (col == COL_LAST) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if ((col == COL_LAST) && (row == ROW_LAST)) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((inflight == '0) && (fifo_count == '0)) begin
            state      <= S_DONE;
            frame_done <= 1'b1;
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          frame_done <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // lb_old holds the line two above the current one, lb_mid the line directly above.
  logic [7:0]    lb_old [IMG_WIDTH];
  logic [7:0]    lb_mid [IMG_WIDTH];
  logic [7:0]    col_old;
  logic [7:0]    col_mid;
  logic [7:0]    win [9];
  logic [XW-1:0] wtag_x;
  logic [YW-1:0] wtag_y;

  assign col_old = lb_old[col];
  assign col_mid = lb_mid[col];

  always_ff @(posedge clk) begin
    if (accept) begin
      lb_old[col] <= col_mid;
      lb_mid[col] <= pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) win[i] <= '0;
      win_valid <= 1'b0;
      wtag_x    <= '0;
      wtag_y    <= '0;
    end else begin
      win_valid <= issue;
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          win[r*3]   <= win[r*3+1];
          win[r*3+1] <= win[r*3+2];
        end
        win[2] <= col_old;
        win[5] <= col_mid;
        win[8] <= pix_in;
      end
      if (issue) begin
        wtag_x <= col - 1'b1;
        wtag_y <= row - 1'b1;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < 9; i++) win_data[8*i +: 8] = win[i];
  end

  // The win_valid register is the first latency cycle, so the tag pipe's last stage
  // lines up with grad_valid_in exactly PIPE_LAT cycles after win_valid.
  logic          tag_v [PIPE_LAT];
  logic [XW-1:0] tag_x [PIPE_LAT];
  logic [YW-1:0] tag_y [PIPE_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PIPE_LAT; k++) begin
        tag_v[k] <= 1'b0;
        tag_x[k] <= '0;
        tag_y[k] <= '0;
      end
    end else begin
      tag_v[0] <= win_valid;
      tag_x[0] <= wtag_x;
      tag_y[0] <= wtag_y;
      for (int k = 1; k < PIPE_LAT; k++) begin
        tag_v[k] <= tag_v[k-1];
        tag_x[k] <= tag_x[k-1];
        tag_y[k] <= tag_y[k-1];
      end
    end
  end

  assign push = tag_v[PIPE_LAT-1];

  logic [EW-1:0] fifo_mem [OUT_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [EW-1:0] head;

  // inflight counts a window from issue until its result lands in the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      sync_err   <= 1'b0;
    end else begin
      inflight   <= inflight + CW'(issue) - CW'(push);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (grad_valid_in != push) sync_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {grad_mag_in, grad_dir_in, tag_x[PIPE_LAT-1], tag_y[PIPE_LAT-1]};
  end

  assign head = fifo_mem[rd_ptr];

  always_comb begin
    {out_mag, out_dir, out_x, out_y} = '0;
    if (out_valid) {out_mag, out_dir, out_x, out_y} = head;
  end

endmodule

// File: tb/tb_gradient_frame_scheduler.sv
// Bench for gradient_frame_scheduler: scenario table of whole frames checked against an
// image-level Sobel reference, plus hand sequences for stall, sync error and reset.
module tb_gradient_frame_scheduler;
  localparam int W  = 5;
  localparam int H  = 5;
  localparam int PL = 4;
  localparam int D  = 8;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
  localparam int RW = 11 + 2 + XW + YW;
  localparam int TIMEOUT = 3000;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [7:0]    pix_in = '0;
  logic          pix_in_valid = 1'b0;
  logic          pix_in_ready;
  logic [71:0]   win_data;
  logic          win_valid;
  logic [10:0]   grad_mag_in;
  logic [1:0]    grad_dir_in;
  logic          grad_valid_in;
  logic [10:0]   out_mag;
  logic [1:0]    out_dir;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          busy;
  logic          frame_done;
  logic          sync_err;
  logic [1:0]    dbg_state;
  logic          inject = 1'b0;

  gradient_frame_scheduler #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIPE_LAT(PL), .OUT_FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .pix_in(pix_in), .pix_in_valid(pix_in_valid), .pix_in_ready(pix_in_ready),
    .win_data(win_data), .win_valid(win_valid),
    .grad_mag_in(grad_mag_in), .grad_dir_in(grad_dir_in), .grad_valid_in(grad_valid_in),
    .out_mag(out_mag), .out_dir(out_dir), .out_x(out_x), .out_y(out_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .frame_done(frame_done), .sync_err(sync_err), .dbg_state(dbg_state)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // gradient rule shared by the image reference and the stand-in datapath
  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  function automatic logic [12:0] grad(input int gx, input int gy);
    int ax, ay;
    logic [1:0] d;
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    if (2 * ay < ax)                d = 2'd0;
    else if (2 * ax < ay)           d = 2'd2;
    else if ((gx < 0) == (gy < 0))  d = 2'd1;
    else                            d = 2'd3;
    return {11'(isqrt(gx * gx + gy * gy)), d};
  endfunction

  function automatic int px(input logic [71:0] w, input int r, input int c);
    return int'(w[8*(r*3+c) +: 8]);
  endfunction

  function automatic int wgx(input logic [71:0] w);
    return px(w,0,2) + 2*px(w,1,2) + px(w,2,2) - px(w,0,0) - 2*px(w,1,0) - px(w,2,0);
  endfunction

  function automatic int wgy(input logic [71:0] w);
    return px(w,2,0) + 2*px(w,2,1) + px(w,2,2) - px(w,0,0) - 2*px(w,0,1) - px(w,0,2);
  endfunction

  // stand-in fixed-latency datapath fed from the DUT's window output
  logic        dp_v [PL];
  logic [12:0] dp_r [PL];
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PL; k++) begin
        dp_v[k] <= 1'b0;
        dp_r[k] <= '0;
      end
    end else begin
      dp_v[0] <= win_valid;
      dp_r[0] <= grad(wgx(win_data), wgy(win_data));
      for (int k = 1; k < PL; k++) begin
        dp_v[k] <= dp_v[k-1];
        dp_r[k] <= dp_r[k-1];
      end
    end
  end
  assign grad_valid_in = dp_v[PL-1] | inject;
  assign {grad_mag_in, grad_dir_in} = dp_r[PL-1];

  // reference image and expected result queue
  int img [H][W];
  logic [RW-1:0] exp_q[$];

  task automatic build_frame(input int mode);
    int gx, gy;
    exp_q.delete();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = (mode == 0) ? (x + 10 * y) : int'($urandom_range(255));
    for (int y = 1; y < H - 1; y++)
      for (int x = 1; x < W - 1; x++) begin
        gx = (img[y-1][x+1] + 2*img[y][x+1] + img[y+1][x+1])
           - (img[y-1][x-1] + 2*img[y][x-1] + img[y+1][x-1]);
        gy = (img[y+1][x-1] + 2*img[y+1][x] + img[y+1][x+1])
           - (img[y-1][x-1] + 2*img[y-1][x] + img[y-1][x+1]);
        exp_q.push_back({grad(gx, gy), XW'(x), YW'(y)});
      end
  endtask

  // scoreboard / monitor
  int cyc = 0;
  int win_cnt = 0;
  int done_cnt = 0;
  int last_pop_cyc = 0;
  int done_cyc = 0;
  logic [RW-1:0] sb_e;
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (win_valid) win_cnt++;
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        last_pop_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL sb_extra: result x=%0d y=%0d arrived, expected queue size 0", out_x, out_y);
        end else begin
          sb_e = exp_q.pop_front();
          check("sb_mag", out_mag, sb_e[RW-1 -: 11]);
          check("sb_dir", out_dir, sb_e[XW+YW+1 -: 2]);
          check("sb_x",   out_x,   sb_e[YW +: XW]);
          check("sb_y",   out_y,   sb_e[0 +: YW]);
        end
      end
    end
  end

  // driver tasks
  int pix_accepted = 0;

  task automatic drive_pixels(input int npix, input int vgap, input bit spam);
    int  idx = 0;
    int  guard = 0;
    bit  acc;
    bit  spammed = 1'b0;
    pix_accepted = 0;
    while (idx < npix && guard < TIMEOUT) begin
      if (!pix_in_valid && int'($urandom_range(99)) >= vgap) begin
        pix_in_valid = 1'b1;
        pix_in = 8'(img[idx / W][idx % W]);
      end
      if (spam && !spammed && idx == 7) begin
        start = 1'b1;
        spammed = 1'b1;
      end
      @(negedge clk);
      acc = pix_in_valid && pix_in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (acc) begin
        idx++;
        pix_accepted = idx;
        pix_in_valid = 1'b0;
      end
      guard++;
    end
    pix_in_valid = 1'b0;
    if (idx < npix) check("pix_intake_timeout", idx, npix);
    if (spam) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_pix_in_ready"}, pix_in_ready, 0);
    check({tag, "_win_valid"},    win_valid, 0);
    check({tag, "_win_data_nz"},  |win_data, 0);
    check({tag, "_out_valid"},    out_valid, 0);
    check({tag, "_out_mag"},      out_mag, 0);
    check({tag, "_out_dir"},      out_dir, 0);
    check({tag, "_out_x"},        out_x, 0);
    check({tag, "_out_y"},        out_y, 0);
    check({tag, "_busy"},         busy, 0);
    check({tag, "_frame_done"},   frame_done, 0);
    check({tag, "_sync_err"},     sync_err, 0);
    check({tag, "_state"},        dbg_state, 0);
  endtask

  typedef struct {
    int mode;
    int vgap;
    int rgap;
    int hold;
    bit spam;
    int exp_wins;
    int exp_done;
  } scen_t;

  task automatic run_frame(input scen_t s);
    int win_base, done_base, c;
    build_frame(s.mode);
    win_base  = win_cnt;
    done_base = done_cnt;
    pulse_start();
    c = 0;
    fork
      drive_pixels(W * H, s.vgap, s.spam);
      begin
        while (done_cnt == done_base && c < TIMEOUT) begin
          out_ready = (c < s.hold) ? 1'b0 : (int'($urandom_range(99)) >= s.rgap);
          @(posedge clk); #1;
          c++;
          if (s.hold != 0 && c == s.hold) begin
            check("stall_windows",     win_cnt - win_base, D);
            check("stall_accepted",    pix_accepted, (H - 1) * W + (W - 1));
            check("stall_pix_pending", pix_in_valid, 1);
            check("stall_pix_ready",   pix_in_ready, 0);
            check("stall_out_valid",   out_valid, 1);
          end
        end
      end
    join
    out_ready = 1'b1;
    check("frame_completed",  done_cnt != done_base, 1);
    check("frame_windows",    win_cnt - win_base, s.exp_wins);
    check("frame_results_left", exp_q.size(), 0);
    check("frame_sync_err",   sync_err, 0);
    check("done_after_pop",   done_cyc - last_pop_cyc, 2);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("frame_done_pulses", done_cnt - done_base, s.exp_done);
    check("frame_busy_after",  busy, 0);
  endtask

  scen_t tbl [5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks so far", checks);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, 0,  0,  0,   1'b0, 9, 1};
    tbl[1] = '{0, 0,  0,  150, 1'b0, 9, 1};
    tbl[2] = '{1, 50, 50, 0,   1'b0, 9, 1};
    tbl[3] = '{1, 50, 50, 0,   1'b1, 9, 1};
    tbl[4] = '{1, 20, 70, 0,   1'b1, 9, 1};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle("reset");

    for (int i = 0; i < 5; i++) run_frame(tbl[i]);

    // stray datapath strobe with nothing in flight
    @(posedge clk); #1;
    inject = 1'b1;
    @(posedge clk); #1;
    inject = 1'b0;
    @(negedge clk);
    check("sync_err_set",    sync_err, 1);
    check("sync_fifo_empty", out_valid, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("sync_err_sticky", sync_err, 1);

    // abort a frame after 12 pixels
    build_frame(0);
    pulse_start();
    drive_pixels(12, 0, 1'b0);
    check("midrst_busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle("midrst");
    run_frame(tbl[0]);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/gradient_frame_scheduler.md
Name: gradient_frame_scheduler

Overview:
Sequences a raster pixel stream into the Sobel gradient datapath. It holds two line buffers, builds 3x3 windows, and issues them as a 72-bit window word with a valid strobe. It tags each issued window with its centre coordinate and realigns that tag with the datapath's fixed-latency magnitude/direction result. Results go out through a small output FIFO with valid/ready; a credit counter throttles pixel intake so the non-stallable datapath can never overflow that FIFO.

Parameters:
IMG_WIDTH, 256, pixels per line (>=3)
IMG_HEIGHT, 256, lines per frame (>=3)
PIPE_LAT, 4, cycles from win_valid to grad_valid_in (mult, sum, square, magnitude)
OUT_FIFO_DEPTH, 8, output FIFO entries (power of 2, >= PIPE_LAT)
XW / YW, $clog2(IMG_WIDTH) / $clog2(IMG_HEIGHT), coordinate widths (derived)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a frame (ignored unless IDLE)
pix_in  in  8  raster pixel, row-major, top-left first
pix_in_valid  in  1  pixel present
pix_in_ready  out  1  pixel accepted when valid & ready
win_data  out  72  3x3 window; byte i = row i/3 (0 = oldest line), col i%3 (0 = leftmost)
win_valid  out  1  window valid, one cycle per window
grad_mag_in  in  11  magnitude from datapath
grad_dir_in  in  2  direction from datapath
grad_valid_in  in  1  datapath result valid
out_mag  out  11  FIFO head magnitude
out_dir  out  2  FIFO head direction
out_x  out  XW  centre column of result
out_y  out  YW  centre row of result
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer accepts head
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse at frame end
sync_err  out  1  sticky: grad_valid_in disagreed with expected tag valid

Behaviour:
- Reset: state IDLE; all counters, FIFO pointers and tag pipe cleared. All outputs 0, including pix_in_ready, win_valid, out_valid, busy, frame_done and sync_err. Line-buffer RAM contents are not reset. Reset mid-frame aborts the frame and drops queued results.
- FSM:
  - IDLE -> RUN on start. Column/row counters zeroed.
  - RUN -> DRAIN when the pixel at (IMG_WIDTH-1, IMG_HEIGHT-1) is accepted.
  - DRAIN -> DONE when the tag pipe is empty and the FIFO is empty.
  - DONE -> IDLE after 1 cycle; frame_done = 1 only in DONE.
  - start outside IDLE is ignored.
- Intake:
  - An accept (valid & ready) writes the pixel into the line buffers and the window shift register, then advances col.
  - col wraps at IMG_WIDTH-1 to 0 and increments row.
- Window issue:
  - An accept at col>=2 and row>=2 drives win_valid on the next cycle, registered, together with its win_data.
  - Tag = (col-1, row-1), entering a PIPE_LAT-deep tag pipe.
  - Windows per frame = (W-2)*(H-2). No border padding.
- Credits:
  - inflight = tags in pipe; credits = OUT_FIFO_DEPTH - fifo_count - inflight.
  - pix_in_ready = (state==RUN) & (credits>0 | !issue_would_occur).
  - Non-issuing pixels (first two columns/rows) are never throttled.
- Result capture:
  - When the tag pipe's output stage is valid, {grad_mag_in, grad_dir_in, tag} is pushed into the FIFO.
  - grad_valid_in != tag-valid sets sync_err. The push follows the tag, not grad_valid_in.
  - The FIFO cannot overflow by construction.
- Output:
  - Standard valid/ready; the head is held stable while out_valid & !out_ready.
  - Simultaneous push and pop at full or empty is legal; count stays consistent. Push into an empty FIFO is visible on the next cycle.
- Widths: col/row counters are XW/YW bits; credit arithmetic is $clog2(OUT_FIFO_DEPTH)+1 bits, unsigned, never negative.

Test Plan:
- W=H=5, PIPE_LAT=4, out_ready=1, pixel=x+10*y, datapath = real gradient stage. Expect:
  - exactly 9 win_valid pulses;
  - outputs at (1,1),(2,1),(3,1),(1,2)..(3,3) in order, each out_mag=80;
  - frame_done one pulse after the last pop, then busy=0.
- Same frame with out_ready=0 throughout: at most 8 windows issued, then pix_in_ready=0 with pixel at an issuing position pending. Releasing out_ready completes all 9, in order, with no loss.
- Random pix_in_valid/out_ready gaps (50%): scoreboard gets 9 results, coordinates monotone, no duplicates, sync_err=0.
- Inject an extra grad_valid_in pulse with an empty tag pipe: sync_err=1 and stays 1 until rst; FIFO count unaffected.
- Assert rst for 1 cycle mid-RUN (after 12 pixels): all outputs 0 next cycle, state IDLE. A new start plus a full frame yields 9 correct results.
- start pulsed during RUN and DRAIN: no effect on counters or window count; a single frame_done.
